sprite_blitter: RTL and testbench

- Draws one rectangular sprite into the 320x240, 3-bit-colour VGA frame buffer.
- Started by the animation control FSM with an origin (x0, y0) and a ROM base address.
- Sweeps the sprite raster, issues sprite-ROM addresses and aligns the returned colour with its pixel coordinate.
- Drives x/y/colour/plot straight into vga_adapter, skipping transparent pixels and off-screen pixels. Also supports an erase pass that paints a flat background colour.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/blit_delay_line.sv | 29 ++
 rtl/sprite_blitter.sv | 164 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared screen geometry, bus widths, FSM encoding and pixel-slot type for the
// sprite blitter and its delay line.
package vga_pkg;

  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;
  localparam int X_W        = 9;
  localparam int Y_W        = 8;
  localparam int COLOUR_W   = 3;
  localparam int ROM_ADDR_W = 14;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } state_t;

  // Coordinates carry one extra bit so an overflowing sum reads as off-screen.
  typedef struct packed {
    logic           valid;
    logic [X_W:0]   x;
    logic [Y_W:0]   y;
  } slot_t;

  function automatic logic on_screen(input logic [X_W:0] x, input logic [Y_W:0] y);
    return (x < (X_W+1)'(SCREEN_W)) && (y < (Y_W+1)'(SCREEN_H));
  endfunction

endpackage

// File: rtl/blit_delay_line.sv
// DEPTH-stage shift register that carries each pixel's coordinates alongside
// the sprite-ROM read so they meet the returned colour in the same cycle.
module blit_delay_line
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  slot_t head,
  output slot_t tail
);

  slot_t stages [DEPTH];

  // NOTE: every stage is cleared on reset, not just the valid bits' first
  // stage, so no half-fetched pixel can surface after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= head;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tail = stages[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Sweeps one SPR_W x SPR_H sprite out of ROM and streams its pixels to the
// VGA adapter, clipping off-screen and transparent pixels; also erases.
module sprite_blitter
  import vga_pkg::*;
#(
  parameter int                  SPR_W       = 80,
  parameter int                  SPR_H       = 120,
  parameter int                  ROM_LAT     = 1,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = 3'b111
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  erase,
  input  logic [X_W-1:0]        x0,
  input  logic [Y_W-1:0]        y0,
  input  logic [ROM_ADDR_W-1:0] rom_base,
  input  logic [COLOUR_W-1:0]   bg_colour,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [COLOUR_W-1:0]   rom_q,
  output logic [X_W-1:0]        x_out,
  output logic [Y_W-1:0]        y_out,
  output logic [COLOUR_W-1:0]   colour_out,
  output logic                  plot,
  output logic                  busy,
  output logic                  done
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int CNT_W = $clog2(ROM_LAT + 2);

  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(SPR_H - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROM_LAT);

  state_t                state, state_next;
  logic                  erase_q;
  logic [X_W-1:0]        x0_q;
  logic [Y_W-1:0]        y0_q;
  logic [COLOUR_W-1:0]   bg_q;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [CNT_W-1:0]      drain_cnt;
  logic                  last_pixel;
  slot_t                 head, tail;
  logic                  draw;
  logic [COLOUR_W-1:0]   pixel_colour;

  assign last_pixel = (col == LAST_COL) && (row == LAST_ROW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves one unassigned and a latch is never inferred.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_pixel) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      erase_q   <= 1'b0;
      x0_q      <= '0;
      y0_q      <= '0;
      bg_q      <= '0;
      col       <= '0;
      row       <= '0;
      drain_cnt <= '0;
      rom_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            erase_q  <= erase;
            x0_q     <= x0;
            y0_q     <= y0;
            bg_q     <= bg_colour;
            col      <= '0;
            row      <= '0;
            rom_addr <= rom_base;
          end
        end
        ST_RUN: begin
          drain_cnt <= '0;
          if (last_pixel) begin
            // Address stays on the final pixel through the drain.
            col <= '0;
            row <= '0;
          end else begin
            rom_addr <= rom_addr + ROM_ADDR_W'(1);
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        ST_DRAIN: drain_cnt <= drain_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    head.valid = (state == ST_RUN);
    head.x     = (X_W+1)'(x0_q) + (X_W+1)'(col);
    head.y     = (Y_W+1)'(y0_q) + (Y_W+1)'(row);
  end

  blit_delay_line #(
    .DEPTH (ROM_LAT)
  ) u_delay_line (
    .clk   (clk),
    .rst_n (reset),
    .head  (head),
    .tail  (tail)
  );

  assign pixel_colour = erase_q ? bg_q : rom_q;
  assign draw = tail.valid && on_screen(tail.x, tail.y) &&
                (erase_q || (rom_q != TRANSPARENT));

  // Skipped pixels leave the adapter bus untouched; only plot drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
    end else begin
      plot <= draw;
      if (draw) begin
        x_out      <= tail.x[X_W-1:0];
        y_out      <= tail.y[Y_W-1:0];
        colour_out <= pixel_colour;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a 4x3 sprite on two instances (ROM latency 1 and 2)
// compared cycle by cycle against a pixel-list model of the sweep.
module tb_sprite_blitter;

  localparam int SW = 4;
  localparam int SH = 3;
  localparam int N  = SW * SH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start [2];
  logic       erase [2];
  logic [8:0] x0    [2];
  logic [7:0] y0    [2];
  logic [13:0] base [2];
  logic [2:0] bg    [2];

  logic [13:0] rom_addr0, rom_addr1;
  logic [8:0]  x_out0, x_out1;
  logic [7:0]  y_out0, y_out1;
  logic [2:0]  colour0, colour1;
  logic        plot0, plot1, busy0, busy1, done0, done1;
  logic [2:0]  rom_q0 = '0, rom_q1 = '0, rom_p1 = '0;

  logic [2:0] rom [2][16384];

  typedef struct packed {
    logic [13:0] addr;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  c;
    logic        plot;
    logic        busy;
    logic        done;
  } obs_t;
  obs_t obs [2];

  sprite_blitter #(.SPR_W(SW), .SPR_H(SH), .ROM_LAT(1), .TRANSPARENT(3'b111)) dut0 (
    .clk(clk), .reset(rst_n), .start(start[0]), .erase(erase[0]), .x0(x0[0]),
    .y0(y0[0]), .rom_base(base[0]), .bg_colour(bg[0]), .rom_addr(rom_addr0),
    .rom_q(rom_q0), .x_out(x_out0), .y_out(y_out0), .colour_out(colour0),
    .plot(plot0), .busy(busy0), .done(done0)
  );

  sprite_blitter #(.SPR_W(SW), .SPR_H(SH), .ROM_LAT(2), .TRANSPARENT(3'b111)) dut1 (
    .clk(clk), .reset(rst_n), .start(start[1]), .erase(erase[1]), .x0(x0[1]),
    .y0(y0[1]), .rom_base(base[1]), .bg_colour(bg[1]), .rom_addr(rom_addr1),
    .rom_q(rom_q1), .x_out(x_out1), .y_out(y_out1), .colour_out(colour1),
    .plot(plot1), .busy(busy1), .done(done1)
  );

  // Sprite ROMs with one and two cycles of read latency.
  always @(posedge clk) begin
    rom_q0 <= rom[0][rom_addr0];
    rom_p1 <= rom[1][rom_addr1];
    rom_q1 <= rom_p1;
  end

  always_comb begin
    obs[0] = {rom_addr0, x_out0, y_out0, colour0, plot0, busy0, done0};
    obs[1] = {rom_addr1, x_out1, y_out1, colour1, plot1, busy1, done1};
  end

  int checks = 0;
  int errors = 0;
  int lx [2];
  int ly [2];
  int lc [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_bus(input int d, input string where, input int exp_plot,
                           input int exp_busy, input int exp_done);
    check($sformatf("d%0d plot %s", d, where), 32'(obs[d].plot), exp_plot);
    check($sformatf("d%0d busy %s", d, where), 32'(obs[d].busy), exp_busy);
    check($sformatf("d%0d done %s", d, where), 32'(obs[d].done), exp_done);
    check($sformatf("d%0d x %s", d, where), 32'(obs[d].x), lx[d]);
    check($sformatf("d%0d y %s", d, where), 32'(obs[d].y), ly[d]);
    check($sformatf("d%0d colour %s", d, where), 32'(obs[d].c), lc[d]);
  endtask

  task automatic fill_pattern(input int d);
    for (int i = 0; i < 16384; i++) rom[d][i] = ((i % 8) == 7) ? 3'd1 : 3'(i % 8);
  endtask

  task automatic clear_last();
    for (int d = 0; d < 2; d++) begin
      lx[d] = 0;
      ly[d] = 0;
      lc[d] = 0;
    end
  endtask

  // Entered and left on a falling edge. abort_j>0 pulls reset in that cycle.
  task automatic run_sweep(input int d, input bit er, input int x, input int y,
                           input int b, input int bgc, input int abort_j,
                           input bit mid_start, input bit b2b);
    int lat;
    bit vis [N];
    int ex [N];
    int ey [N];
    int ec [N];
    lat = (d == 0) ? 1 : 2;
    for (int p = 0; p < N; p++) begin
      ex[p]  = x + (p % SW);
      ey[p]  = y + (p / SW);
      ec[p]  = er ? bgc : int'(rom[d][(b + p) % 16384]);
      vis[p] = (ex[p] < 320) && (ey[p] < 240) && (er || ec[p] != 7);
    end

    erase[d] = er;
    x0[d]    = 9'(x);
    y0[d]    = 8'(y);
    base[d]  = 14'(b);
    bg[d]    = 3'(bgc);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;

    for (int j = 1; j <= N + lat + 2; j++) begin
      int p;
      int ep;
      p  = j - lat - 2;
      ep = (p >= 0 && p < N) ? int'(vis[p]) : 0;
      if (ep != 0) begin
        lx[d] = ex[p];
        ly[d] = ey[p];
        lc[d] = ec[p];
      end
      check_bus(d, $sformatf("cyc%0d", j), ep, (j <= N + lat + 1) ? 1 : 0,
                (j == N + lat + 2) ? 1 : 0);
      if (j <= N)
        check($sformatf("d%0d rom_addr cyc%0d", d, j), 32'(obs[d].addr), (b + j - 1) % 16384);

      if (j == abort_j) begin
        rst_n = 1'b0;
        #1;
        clear_last();
        check_bus(d, "async reset", 0, 0, 0);
        check($sformatf("d%0d rom_addr async reset", d), 32'(obs[d].addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check_bus(d, "after reset", 0, 0, 0);
        end
        return;
      end

      if (mid_start && j == 3) start[d] = 1'b1;
      if (mid_start && j == 4) start[d] = 1'b0;
      if (b2b && j == N + lat + 2) start[d] = 1'b1;
      @(negedge clk);
    end
    check_bus(d, "idle", 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      erase[d] = 1'b0;
      x0[d]    = '0;
      y0[d]    = '0;
      base[d]  = '0;
      bg[d]    = '0;
    end
    clear_last();
    fill_pattern(0);
    fill_pattern(1);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_bus(d, "reset", 0, 0, 0);
      check($sformatf("d%0d rom_addr reset", d), 32'(obs[d].addr), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Plain raster, then two transparent pixels, then corner clipping.
    run_sweep(0, 1'b0, 10, 20, 0, 0, 0, 1'b0, 1'b0);
    rom[0][5] = 3'b111;
    rom[0][6] = 3'b111;
    run_sweep(0, 1'b0, 10, 20, 0, 0, 0, 1'b0, 1'b0);
    fill_pattern(0);
    run_sweep(0, 1'b0, 318, 238, 0, 0, 0, 1'b0, 1'b0);

    // Erase paints over transparent ROM entries too.
    rom[0][5] = 3'b111;
    rom[0][6] = 3'b111;
    run_sweep(0, 1'b1, 10, 20, 0, 2, 0, 1'b0, 1'b0);

    // Reset after five pixels, then a clean replay.
    fill_pattern(0);
    run_sweep(0, 1'b0, 10, 20, 0, 0, 7, 1'b0, 1'b0);
    run_sweep(0, 1'b0, 10, 20, 0, 0, 0, 1'b0, 1'b0);

    // Two-cycle ROM: ignored start while busy, start held through done.
    run_sweep(1, 1'b0, 10, 20, 0, 0, 0, 1'b1, 1'b1);
    run_sweep(1, 1'b0, 50, 60, 16380, 0, 0, 1'b0, 1'b0);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16384; i++) rom[d][i] = 3'($urandom_range(0, 7));
    for (int k = 0; k < 24; k++) begin
      int rx;
      int ry;
      int rb;
      rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 511)) : int'($urandom_range(0, 319));
      ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(220, 255)) : int'($urandom_range(0, 239));
      rb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(16375, 16383)) : int'($urandom_range(0, 16383));
      run_sweep(k % 2, 1'($urandom_range(0, 1)), rx, ry, rb, int'($urandom_range(0, 7)),
                0, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
